// File: rtl/lu_operand_sequencer.sv
// Two-beat operand loader for a 3-bit comparator.
// Captures the comparator answer and counts true results.
module lu_operand_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [2:0]       cmp_a,
  output logic [2:0]       cmp_b,
  output logic             cmp_select,
  input  logic             cmp_result,
  input  logic             flush,
  output logic             out_valid,
  output logic             out_result,
  input  logic             out_ready,
  output logic [CNT_W-1:0] hit_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    EVAL  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] HIT_MAX = '1;

  state_e           state_q, state_d;
  logic [2:0]       a_q, a_d;
  logic [2:0]       b_q, b_d;
  logic             sel_q, sel_d;
  logic             vld_q, vld_d;
  logic             res_q, res_d;
  logic [CNT_W-1:0] hit_q, hit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      vld_q   <= 1'b0;
      res_q   <= 1'b0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    res_d   = res_q;
    hit_d   = hit_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_data;
          sel_d   = in_sel;
          state_d = GOT_A;
        end
      end
      GOT_A: begin
        // Abort wins over a beat offered on the same edge
        if (flush) begin
          state_d = IDLE;
        end else if (in_valid) begin
          b_d     = in_data;
          state_d = EVAL;
        end
      end
      EVAL: begin
        res_d   = cmp_result;
        vld_d   = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
          if (res_q && (hit_q != HIT_MAX)) begin
            hit_d = hit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE) || (state_q == GOT_A);
  assign cmp_a      = a_q;
  assign cmp_b      = b_q;
  assign cmp_select = sel_q;
  assign out_valid  = vld_q;
  assign out_result = res_q;
  assign hit_count  = hit_q;

endmodule

// File: tb/tb_lu_operand_sequencer.sv
// Self-checking bench for lu_operand_sequencer.
// Comparator and counter expectations come from a transaction-level model.
module tb_lu_operand_sequencer;

  localparam int CNT_W = 4;
  localparam int HMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [2:0]       in_data;
  logic             in_sel;
  logic             in_ready;
  logic [2:0]       cmp_a;
  logic [2:0]       cmp_b;
  logic             cmp_select;
  logic             cmp_result;
  logic             flush;
  logic             out_valid;
  logic             out_result;
  logic             out_ready;
  logic [CNT_W-1:0] hit_count;

  int checks = 0;
  int errors = 0;
  int exp_hit = 0;

  lu_operand_sequencer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_select (cmp_select),
    .cmp_result (cmp_result),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_ready  (out_ready),
    .hit_count  (hit_count)
  );

  always #5 clk = ~clk;

  // Downstream comparator
  assign cmp_result = cmp_select ? (cmp_a > cmp_b) : (cmp_a < cmp_b);

  function automatic int ref_cmp(int a, int b, int s);
    return (s != 0) ? int'(a > b) : int'(a < b);
  endfunction

  function automatic int sat_add(int h, int r);
    return (h + r > HMAX) ? HMAX : h + r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 1'b0 || hit_count !== '0) begin
      errors++;
      $display("FAIL reset_out got v=%b r=%b h=%0d exp 0 0 0",
               out_valid, out_result, hit_count);
    end
    checks++;
    if (cmp_a !== 3'd0 || cmp_b !== 3'd0 || cmp_select !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmp got a=%0d b=%0d s=%b rdy=%b exp 0 0 0 1",
               cmp_a, cmp_b, cmp_select, in_ready);
    end
    in_valid = 1'b1; in_data = 3'd7; in_sel = 1'b1;
    tick(); tick();
    checks++;
    if (cmp_a !== 3'd0 || cmp_select !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_accept got a=%0d s=%b rdy=%b exp 0 0 1",
               cmp_a, cmp_select, in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    exp_hit = 0;
    tick();
  endtask

  task automatic test_basic;
    beat(3'd1, 1'b0);
    checks++;
    if (cmp_a !== 3'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_a got a=%0d rdy=%b exp 1 1", cmp_a, in_ready);
    end
    beat(3'd2, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_eval got v=%b rdy=%b exp 0 0", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 1'b1 || cmp_a !== 3'd1 ||
        cmp_b !== 3'd2 || cmp_select !== 1'b0) begin
      errors++;
      $display("FAIL basic_out got v=%b r=%b a=%0d b=%0d s=%b exp 1 1 1 2 0",
               out_valid, out_result, cmp_a, cmp_b, cmp_select);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_hit = sat_add(exp_hit, 1);
    checks++;
    if (hit_count !== CNT_W'(exp_hit) || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_hit got h=%0d v=%b exp %0d 0", hit_count, out_valid, exp_hit);
    end
  endtask

  task automatic test_back_pressure;
    beat(3'd7, 1'b1);
    beat(3'd0, 1'b0);
    tick();
    in_valid = 1'b1; in_data = 3'd5; in_sel = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 1'b1 || cmp_a !== 3'd7) begin
        errors++;
        $display("FAIL bp_hold%0d got rdy=%b v=%b r=%b a=%0d exp 0 1 1 7",
                 i, in_ready, out_valid, out_result, cmp_a);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_hit = sat_add(exp_hit, 1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cmp_a !== 3'd7 ||
        hit_count !== CNT_W'(exp_hit)) begin
      errors++;
      $display("FAIL bp_release got v=%b rdy=%b a=%0d h=%0d exp 0 1 7 %0d",
               out_valid, in_ready, cmp_a, hit_count, exp_hit);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (cmp_a !== 3'd5 || cmp_select !== 1'b1) begin
      errors++;
      $display("FAIL bp_late_a got a=%0d s=%b exp 5 1", cmp_a, cmp_select);
    end
    beat(3'd0, 1'b0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_hit = sat_add(exp_hit, ref_cmp(5, 0, 1));
  endtask

  task automatic test_false_result;
    beat(3'd5, 1'b1);
    beat(3'd6, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 1'b0) begin
      errors++;
      $display("FAIL false_out got v=%b r=%b exp 1 0", out_valid, out_result);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (hit_count !== CNT_W'(exp_hit)) begin
      errors++;
      $display("FAIL false_hit got %0d exp %0d", hit_count, exp_hit);
    end
  endtask

  task automatic test_flush;
    beat(3'd3, 1'b0);
    in_valid = 1'b1; in_data = 3'd4; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || cmp_a !== 3'd3 || out_valid !== 1'b0 ||
        hit_count !== CNT_W'(exp_hit)) begin
      errors++;
      $display("FAIL flush_drop got rdy=%b a=%0d v=%b h=%0d exp 1 3 0 %0d",
               in_ready, cmp_a, out_valid, hit_count, exp_hit);
    end
    beat(3'd4, 1'b0);
    checks++;
    if (cmp_a !== 3'd4 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_new_a got a=%0d rdy=%b exp 4 1", cmp_a, in_ready);
    end
    beat(3'd5, 1'b0);
    flush = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 1'b1) begin
      errors++;
      $display("FAIL flush_eval got v=%b r=%b exp 1 1", out_valid, out_result);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || cmp_b !== 3'd5) begin
      errors++;
      $display("FAIL flush_hold got v=%b rdy=%b b=%0d exp 1 0 5", out_valid, in_ready, cmp_b);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_hit = sat_add(exp_hit, 1);
    checks++;
    if (hit_count !== CNT_W'(exp_hit)) begin
      errors++;
      $display("FAIL flush_hit got %0d exp %0d", hit_count, exp_hit);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      int a, b, s, r, hold;
      a = $urandom_range(0, 7);
      b = $urandom_range(0, 7);
      s = $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 3) == 0) begin
        beat(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        flush = 1'b1; in_valid = 1'b1; in_data = 3'($urandom_range(0, 7));
        tick();
        flush = 1'b0; in_valid = 1'b0;
      end
      beat(3'(a), 1'(s));
      beat(3'(b), 1'($urandom_range(0, 1)));
      tick();
      r = ref_cmp(a, b, s);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 1'(r) || cmp_a !== 3'(a) ||
          cmp_b !== 3'(b) || cmp_select !== 1'(s)) begin
        errors++;
        $display("FAIL rand%0d_out got v=%b r=%b a=%0d b=%0d s=%b exp 1 %0d %0d %0d %0d",
                 n, out_valid, out_result, cmp_a, cmp_b, cmp_select, r, a, b, s);
      end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 3'($urandom_range(0, 7));
        tick();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || cmp_a !== 3'(a)) begin
          errors++;
          $display("FAIL rand%0d_hold got v=%b rdy=%b a=%0d exp 1 0 %0d",
                   n, out_valid, in_ready, cmp_a, a);
        end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_hit = sat_add(exp_hit, r);
      checks++;
      if (hit_count !== CNT_W'(exp_hit) || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_hit got h=%0d v=%b exp %0d 0", n, hit_count, out_valid, exp_hit);
      end
    end
  endtask

  task automatic test_saturation;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    exp_hit = 0;
    checks++;
    if (hit_count !== '0) begin
      errors++;
      $display("FAIL sat_clear got %0d exp 0", hit_count);
    end
    tick();
    for (int n = 0; n < 16; n++) begin
      int a;
      a = $urandom_range(0, 6);
      beat(3'(a), 1'b0);
      beat(3'($urandom_range(a + 1, 7)), 1'b0);
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_hit = sat_add(exp_hit, 1);
      if (n >= 13) begin
        checks++;
        if (hit_count !== CNT_W'(exp_hit)) begin
          errors++;
          $display("FAIL sat%0d got %0d exp %0d", n, hit_count, exp_hit);
        end
      end
    end
    beat(3'd2, 1'b1);
    beat(3'd1, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp_hit = 0;
    checks++;
    if (out_valid !== 1'b0 || hit_count !== '0 || in_ready !== 1'b1 ||
        cmp_a !== 3'd0 || cmp_b !== 3'd0 || out_result !== 1'b0) begin
      errors++;
      $display("FAIL sat_async_rst got v=%b h=%0d rdy=%b a=%0d b=%0d r=%b exp 0 0 1 0 0 0",
               out_valid, hit_count, in_ready, cmp_a, cmp_b, out_result);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_false_result();
    test_flush();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lu_operand_sequencer.md
LU_OPERAND_SEQUENCER -- requirements
Module: lu_operand_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, giving the width of the true-result counter.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid  input  1  an operand beat is present on in_data.
REQ-005 The block SHALL have port in_data  input  3  operand value; first beat is A, second beat is B.
REQ-006 The block SHALL have port in_sel  input  1  compare mode, sampled with beat A only; 0 = test A<B, 1 = test A>B.
REQ-007 The block SHALL have port in_ready  output  1  the block accepts a beat this cycle.
REQ-008 The block SHALL have ports cmp_a, cmp_b (output, 3 each) and cmp_select (output, 1), which are the registered operands and mode driven to the downstream 3-bit comparator.
REQ-009 The block SHALL have port cmp_result  input  1  the comparator's combinational answer for cmp_a, cmp_b and cmp_select.
REQ-010 The block SHALL have port flush  input  1  synchronous abort of a partially loaded operand pair.
REQ-011 The block SHALL have port out_valid  output  1  out_result is valid.
REQ-012 The block SHALL have port out_result  output  1  captured comparison answer.
REQ-013 The block SHALL have port out_ready  input  1  the consumer accepts out_result.
REQ-014 The block SHALL have port hit_count  output  CNT_W  number of accepted results equal to 1, saturating.

Function
REQ-015 The FSM SHALL have the states IDLE, GOT_A, EVAL and HOLD.
REQ-016 in_ready SHALL be 1 exactly in IDLE and GOT_A; a beat is accepted on an edge where in_valid=1 and in_ready=1.
REQ-017 IDLE with a beat accepted SHALL load cmp_a<=in_data and cmp_select<=in_sel, then go to GOT_A; otherwise the FSM stays in IDLE.
REQ-018 GOT_A with a beat accepted SHALL load cmp_b<=in_data, then go to EVAL; in_sel SHALL be ignored on this beat.
REQ-019 EVAL SHALL last exactly one cycle; on its closing edge out_result<=cmp_result and out_valid<=1, then the FSM goes to HOLD.
REQ-020 Latency: if beat B is accepted on edge N, out_valid SHALL be 1 from edge N+1 onward.
REQ-021 HOLD SHALL keep out_valid, out_result, cmp_a, cmp_b and cmp_select constant until an edge where out_ready=1.
REQ-022 On that edge, HOLD SHALL clear out_valid, go to IDLE, and increment hit_count if out_result=1.
REQ-023 hit_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 out_ready SHALL be ignored outside HOLD; a beat offered in EVAL or HOLD SHALL be neither accepted nor lost, because in_ready=0.
REQ-025 flush=1 in GOT_A SHALL return the FSM to IDLE and discard A; a beat presented on the same edge SHALL NOT be accepted.
REQ-026 flush=1 in IDLE, EVAL or HOLD SHALL have no effect.
REQ-027 flush SHALL never alter hit_count, out_result or out_valid.
REQ-028 cmp_a, cmp_b and cmp_select SHALL change only on accepted beats, so the comparator inputs are stable throughout EVAL and HOLD.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock edge, force the FSM to IDLE and all of these to 0: cmp_a, cmp_b, cmp_select, out_valid, out_result, hit_count.
REQ-030 While rst_n=0, in_ready SHALL be 1 (the IDLE value) and no beat SHALL be accepted.
REQ-031 Reset asserted mid-transaction, in any state, SHALL discard that transaction with no count update.
REQ-032 After rst_n rises, the first accepted beat SHALL be treated as A.

Verification
REQ-033 Reset: drive rst_n=0 between clock edges -> out_valid, out_result, hit_count, cmp_a, cmp_b, cmp_select all 0 at once; in_ready=1.
REQ-034 Basic: A=001 with sel=0, then B=010, comparator model returns 1, out_ready=1 -> out_valid=1 one edge after B; out_result=1; cmp_a=001, cmp_b=010, cmp_select=0; hit_count=1 after the handshake.
REQ-035 Back-pressure: A=111 with sel=1, B=000, out_ready=0 for 3 cycles while in_valid=1 with data 101 -> in_ready=0, out_valid stays 1, out_result=1, cmp_a=111; 101 is not captured until out_ready=1 returns the FSM to IDLE.
REQ-036 False result: A=101 with sel=1, B=110 -> out_result=0; hit_count unchanged.
REQ-037 Flush: accept A=011, pulse flush with in_valid=1 and data 100 on the same edge -> FSM back in IDLE, 100 not accepted; the next beat 100 becomes A (cmp_a=100).
REQ-038 Saturation and async reset: 16 consecutive true results -> hit_count=15 (CNT_W=4); then rst_n=0 during HOLD -> out_valid=0 and hit_count=0 without a clock edge.
